pipe_controller: RTL and testbench

Parametrised control unit for the MIPS 5-stage pipelined CPU. It decodes the ID-stage instruction, tracks in-flight destination registers in EXE/MEM, and generates forwarding selects, stall and flush controls. It also provides reset sequencing and a multi-cycle debug stepper. It replaces the single-cycle decode controller and adds hazard handling plus an extended instruction set.

---
 rtl/pipe_controller_pkg.sv | 108 ++++++++++
 rtl/pipe_controller_debug_stepper.sv | 68 ++++++
 rtl/pipe_controller.sv | 205 ++++++++++++++++++++
 tb/tb_pipe_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_controller_pkg.sv
// Shared encodings, decode/shadow payloads and helpers for the MIPS pipeline controller.
package pipe_controller_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned INST_W = 32;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [2:0] PC_NEXT = 3'd0;
    localparam logic [2:0] PC_JUMP = 3'd1;
    localparam logic [2:0] PC_JR   = 3'd2;
    localparam logic [2:0] PC_BEQ  = 3'd3;
    localparam logic [2:0] PC_BNE  = 3'd4;

    localparam logic [1:0] EXE_A_RS   = 2'd0;
    localparam logic [1:0] EXE_A_LINK = 2'd1;
    localparam logic [1:0] EXE_A_SA   = 2'd2;
    localparam logic [1:0] EXE_B_RT   = 2'd0;
    localparam logic [1:0] EXE_B_IMM  = 2'd1;
    localparam logic [1:0] EXE_B_FOUR = 2'd2;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    localparam logic [1:0] WB_ADDR_RD   = 2'd0;
    localparam logic [1:0] WB_ADDR_RT   = 2'd1;
    localparam logic [1:0] WB_ADDR_LINK = 2'd2;
    localparam logic       WB_DATA_ALU  = 1'b0;
    localparam logic       WB_DATA_MEM  = 1'b1;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_EXE  = 2'd1;
    localparam logic [1:0] FWD_MEM  = 2'd2;

    localparam logic [REG_W-1:0] REG_LINK = 5'd31;

    typedef enum logic [1:0] {
        DBG_RUN  = 2'd0,
        DBG_HALT = 2'd1,
        DBG_STEP = 2'd2
    } dbg_state_e;

    typedef struct packed {
        logic [2:0] pc_src;
        logic       imm_ext;
        logic [1:0] exe_a_src;
        logic [1:0] exe_b_src;
        logic [3:0] exe_alu_oper;
        logic       mem_ren;
        logic       mem_wen;
        logic [1:0] wb_addr_src;
        logic       wb_data_src;
        logic       wb_wen;
        logic       uses_rs;
        logic       uses_rt;
        logic       unrecognized;
    } ctrl_t;

    // wen is only set for a real (non-r0) destination
    typedef struct packed {
        logic             wen;
        logic [REG_W-1:0] addr;
        logic             load;
    } shadow_t;

    function automatic logic reg_hit(input shadow_t s, input logic used,
                                     input logic [REG_W-1:0] src);
        return used && s.wen && (s.addr == src);
    endfunction

endpackage

// File: rtl/pipe_controller_debug_stepper.sv
// Debug run/halt/step sequencer plus datapath reset stretch and clock-enable generation.
module pipe_controller_debug_stepper
    import pipe_controller_pkg::*;
#(
    parameter int unsigned STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              debug_en,
    input  logic              debug_step,
    input  logic [STEP_W-1:0] debug_step_cnt,
    output logic              cpu_en,
    output logic              cpu_rst
);

    dbg_state_e        state_q, state_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              step_q;
    logic              rst_seen_q;
    logic              step_edge;

    assign step_edge = debug_step & ~step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DBG_RUN;
            cnt_q      <= '0;
            step_q     <= 1'b0;
            rst_seen_q <= 1'b0;
            cpu_rst    <= 1'b1;
            cpu_en     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_q     <= debug_step;
            rst_seen_q <= 1'b1;
            cpu_rst    <= ~rst_seen_q;
            cpu_en     <= (state_d != DBG_HALT);
        end
    end

    // Next state; dropping debug_en overrides everything and clears the count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DBG_RUN: begin
                if (debug_en) state_d = DBG_HALT;
            end
            DBG_HALT: begin
                if (step_edge) begin
                    state_d = DBG_STEP;
                    cnt_d   = (debug_step_cnt == '0) ? STEP_W'(1) : debug_step_cnt;
                end
            end
            DBG_STEP: begin
                cnt_d = cnt_q - STEP_W'(1);
                if (cnt_q == STEP_W'(1)) state_d = DBG_HALT;
            end
            default: state_d = DBG_RUN;
        endcase
        if (!debug_en) begin
            state_d = DBG_RUN;
            cnt_d   = '0;
        end
    end

endmodule

// File: rtl/pipe_controller.sv
// MIPS 5-stage pipeline control: ID decode, EXE/MEM destination tracking,
// forwarding/stall/flush generation and debug stepping.
module pipe_controller
    import pipe_controller_pkg::*;
#(
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug_en,
    input  logic              debug_step,
    input  logic [STEP_W-1:0] debug_step_cnt,
    input  logic [31:0]       inst,
    input  logic              exe_branch_taken,
    output logic [2:0]        pc_src,
    output logic              imm_ext,
    output logic [1:0]        exe_a_src,
    output logic [1:0]        exe_b_src,
    output logic [3:0]        exe_alu_oper,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [1:0]        wb_addr_src,
    output logic              wb_data_src,
    output logic              wb_wen,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              unrecognized,
    output logic              cpu_rst,
    output logic              cpu_en
);

    logic [OP_W-1:0]  opcode;
    logic [5:0]       funct;
    logic [REG_W-1:0] rs, rt, rd, dest;
    logic             unused_bits;

    assign opcode      = inst[31:26];
    assign rs          = inst[25:21];
    assign rt          = inst[20:16];
    assign rd          = inst[15:11];
    assign funct       = inst[5:0];
    assign unused_bits = ^inst[10:6];

    ctrl_t   ctrl;
    logic    illegal;
    shadow_t id_sh, exe_q, mem_q;
    logic    hit_exe_a, hit_exe_b, hit_mem_a, hit_mem_b;
    logic    stall_raw;

    // Instruction decode; an illegal encoding leaves every enable low
    always_comb begin
        ctrl         = '0;
        ctrl.imm_ext = 1'b1;
        illegal      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.uses_rs     = 1'b1;
                ctrl.uses_rt     = 1'b1;
                ctrl.wb_wen      = 1'b1;
                ctrl.wb_addr_src = WB_ADDR_RD;
                case (funct)
                    FN_ADD, FN_ADDU: ctrl.exe_alu_oper = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.exe_alu_oper = ALU_SUB;
                    FN_AND:  ctrl.exe_alu_oper = ALU_AND;
                    FN_OR:   ctrl.exe_alu_oper = ALU_OR;
                    FN_XOR:  ctrl.exe_alu_oper = ALU_XOR;
                    FN_NOR:  ctrl.exe_alu_oper = ALU_NOR;
                    FN_SLT:  ctrl.exe_alu_oper = ALU_SLT;
                    FN_SLTU: ctrl.exe_alu_oper = ALU_SLTU;
                    FN_SLL, FN_SRL: begin
                        ctrl.exe_alu_oper = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
                        ctrl.exe_a_src    = EXE_A_SA;
                        ctrl.uses_rs      = 1'b0;
                    end
                    FN_JR: begin
                        ctrl.pc_src  = PC_JR;
                        ctrl.wb_wen  = 1'b0;
                        ctrl.uses_rt = 1'b0;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_J: ctrl.pc_src = PC_JUMP;
            OP_JAL: begin
                ctrl.pc_src      = PC_JUMP;
                ctrl.exe_a_src   = EXE_A_LINK;
                ctrl.exe_b_src   = EXE_B_FOUR;
                ctrl.wb_addr_src = WB_ADDR_LINK;
                ctrl.wb_wen      = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.pc_src       = (opcode == OP_BEQ) ? PC_BEQ : PC_BNE;
                ctrl.exe_alu_oper = ALU_SUB;
                ctrl.uses_rs      = 1'b1;
                ctrl.uses_rt      = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                ctrl.exe_b_src   = EXE_B_IMM;
                ctrl.wb_addr_src = WB_ADDR_RT;
                ctrl.wb_wen      = 1'b1;
                ctrl.uses_rs     = (opcode != OP_LUI);
                case (opcode)
                    OP_SLTI: ctrl.exe_alu_oper = ALU_SLT;
                    OP_ANDI: ctrl.exe_alu_oper = ALU_AND;
                    OP_ORI:  ctrl.exe_alu_oper = ALU_OR;
                    OP_XORI: ctrl.exe_alu_oper = ALU_XOR;
                    OP_LUI:  ctrl.exe_alu_oper = ALU_LUI;
                    default: ctrl.exe_alu_oper = ALU_ADD;
                endcase
                if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
                    ctrl.imm_ext = 1'b0;
                if (opcode == OP_LW) begin
                    ctrl.mem_ren     = 1'b1;
                    ctrl.wb_data_src = WB_DATA_MEM;
                end
            end
            OP_SW: begin
                ctrl.exe_b_src = EXE_B_IMM;
                ctrl.mem_wen   = 1'b1;
                ctrl.uses_rs   = 1'b1;
                ctrl.uses_rt   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl              = '0;
            ctrl.unrecognized = 1'b1;
        end
    end

    always_comb begin
        case (ctrl.wb_addr_src)
            WB_ADDR_RT:   dest = rt;
            WB_ADDR_LINK: dest = REG_LINK;
            default:      dest = rd;
        endcase
        id_sh.wen  = ctrl.wb_wen && (dest != '0);
        id_sh.addr = dest;
        id_sh.load = ctrl.mem_ren;
    end

    assign hit_exe_a = reg_hit(exe_q, ctrl.uses_rs, rs);
    assign hit_exe_b = reg_hit(exe_q, ctrl.uses_rt, rt);
    assign hit_mem_a = reg_hit(mem_q, ctrl.uses_rs, rs);
    assign hit_mem_b = reg_hit(mem_q, ctrl.uses_rt, rt);

    // Data hazards; the youngest producer (EXE) takes forwarding priority
    always_comb begin
        fwd_a_sel = FWD_NONE;
        fwd_b_sel = FWD_NONE;
        if (FWD_EN != 0) begin
            stall_raw = exe_q.load && (hit_exe_a || hit_exe_b);
            if (hit_exe_a)      fwd_a_sel = FWD_EXE;
            else if (hit_mem_a) fwd_a_sel = FWD_MEM;
            if (hit_exe_b)      fwd_b_sel = FWD_EXE;
            else if (hit_mem_b) fwd_b_sel = FWD_MEM;
        end else begin
            stall_raw = hit_exe_a || hit_exe_b || hit_mem_a || hit_mem_b;
        end
    end

    // A taken branch in EXE is older than anything in ID, so it cancels the stall
    assign stall_if_id = stall_raw && !exe_branch_taken;
    assign flush_id_ex = exe_branch_taken;
    assign flush_if_id = exe_branch_taken || (ctrl.pc_src == PC_JUMP) || (ctrl.pc_src == PC_JR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_q <= '0;
            mem_q <= '0;
        end else if (cpu_en) begin
            exe_q <= (stall_if_id || flush_id_ex) ? shadow_t'('0) : id_sh;
            mem_q <= exe_q;
        end
    end

    assign pc_src       = ctrl.pc_src;
    assign imm_ext      = ctrl.imm_ext;
    assign exe_a_src    = ctrl.exe_a_src;
    assign exe_b_src    = ctrl.exe_b_src;
    assign exe_alu_oper = ctrl.exe_alu_oper;
    assign mem_ren      = ctrl.mem_ren;
    assign mem_wen      = ctrl.mem_wen;
    assign wb_addr_src  = ctrl.wb_addr_src;
    assign wb_data_src  = ctrl.wb_data_src;
    assign wb_wen       = ctrl.wb_wen;
    assign unrecognized = ctrl.unrecognized;

    pipe_controller_debug_stepper #(
        .STEP_W (STEP_W)
    ) u_debug_stepper (
        .clk            (clk),
        .rst_n          (rst),
        .debug_en       (debug_en),
        .debug_step     (debug_step),
        .debug_step_cnt (debug_step_cnt),
        .cpu_en         (cpu_en),
        .cpu_rst        (cpu_rst)
    );

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench: one controller with forwarding (index 1) and one without (index 0) on shared inputs.
module tb_pipe_controller;
    import pipe_controller_pkg::*;

    localparam int unsigned STEP_W = 8;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              debug_en, debug_step, exe_branch_taken;
    logic [STEP_W-1:0] debug_step_cnt;
    logic [31:0]       inst;

    logic [2:0] pc_src [2];
    logic [1:0] exe_a_src [2], exe_b_src [2], wb_addr_src [2], fwd_a_sel [2], fwd_b_sel [2];
    logic [3:0] exe_alu_oper [2];
    logic       imm_ext [2], mem_ren [2], mem_wen [2], wb_data_src [2], wb_wen [2];
    logic       stall_if_id [2], flush_if_id [2], flush_id_ex [2], unrecognized [2];
    logic       cpu_rst [2], cpu_en [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_controller #(.FWD_EN(g), .STEP_W(STEP_W)) u_dut (
            .clk              (clk),
            .rst              (rst),
            .debug_en         (debug_en),
            .debug_step       (debug_step),
            .debug_step_cnt   (debug_step_cnt),
            .inst             (inst),
            .exe_branch_taken (exe_branch_taken),
            .pc_src           (pc_src[g]),
            .imm_ext          (imm_ext[g]),
            .exe_a_src        (exe_a_src[g]),
            .exe_b_src        (exe_b_src[g]),
            .exe_alu_oper     (exe_alu_oper[g]),
            .mem_ren          (mem_ren[g]),
            .mem_wen          (mem_wen[g]),
            .wb_addr_src      (wb_addr_src[g]),
            .wb_data_src      (wb_data_src[g]),
            .wb_wen           (wb_wen[g]),
            .fwd_a_sel        (fwd_a_sel[g]),
            .fwd_b_sel        (fwd_b_sel[g]),
            .stall_if_id      (stall_if_id[g]),
            .flush_if_id      (flush_if_id[g]),
            .flush_id_ex      (flush_id_ex[g]),
            .unrecognized     (unrecognized[g]),
            .cpu_rst          (cpu_rst[g]),
            .cpu_en           (cpu_en[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t,
                                           input logic [4:0] d, input logic [5:0] fn);
        return {OP_RTYPE, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s,
                                           input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    int en_cycles;

    initial begin
        rst = 1'b0; debug_en = 1'b0; debug_step = 1'b0; debug_step_cnt = '0;
        inst = NOP; exe_branch_taken = 1'b0;
        #12;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("reset_cpu_rst%0d", k), 32'(cpu_rst[k]), 1);
            check_eq($sformatf("reset_cpu_en%0d", k), 32'(cpu_en[k]), 0);
            check_eq($sformatf("reset_fwd_a%0d", k), 32'(fwd_a_sel[k]), 0);
        end
        @(negedge clk); rst = 1'b1;
        tick();
        check_eq("post_rst_cpu_rst", 32'(cpu_rst[1]), 1);
        check_eq("post_rst_cpu_en", 32'(cpu_en[1]), 1);
        tick();
        check_eq("post_rst2_cpu_rst", 32'(cpu_rst[1]), 0);

        // Decode only, nothing clocked
        inst = i_type(OP_ANDI, 5'd2, 5'd1, 16'h8000); #1;
        check_eq("andi_imm_ext", 32'(imm_ext[1]), 0);
        inst = i_type(OP_ADDI, 5'd2, 5'd1, 16'h8000); #1;
        check_eq("addi_imm_ext", 32'(imm_ext[1]), 1);
        inst = {OP_JAL, 26'd16}; #1;
        check_eq("jal_pc_src", 32'(pc_src[1]), 32'(PC_JUMP));
        check_eq("jal_wb_addr", 32'(wb_addr_src[1]), 32'(WB_ADDR_LINK));
        check_eq("jal_wb_wen", 32'(wb_wen[1]), 1);
        check_eq("jal_flush_if", 32'(flush_if_id[1]), 1);
        inst = {6'h3F, 26'd0}; #1;
        check_eq("ill_unrec", 32'(unrecognized[1]), 1);
        check_eq("ill_wb_wen", 32'(wb_wen[1]), 0);
        inst = r_type(5'd31, 5'd0, 5'd0, FN_JR); #1;
        check_eq("jr_pc_src", 32'(pc_src[1]), 32'(PC_JR));
        check_eq("jr_flush_if", 32'(flush_if_id[1]), 1);
        inst = r_type(5'd0, 5'd1, 5'd2, FN_SLL); #1;
        check_eq("sll_a_src", 32'(exe_a_src[1]), 32'(EXE_A_SA));
        check_eq("sll_alu", 32'(exe_alu_oper[1]), 32'(ALU_SLL));
        inst = i_type(OP_BNE, 5'd1, 5'd2, 16'h0004); #1;
        check_eq("bne_pc_src", 32'(pc_src[1]), 32'(PC_BNE));
        check_eq("bne_wb_wen", 32'(wb_wen[1]), 0);
        inst = i_type(OP_LW, 5'd0, 5'd5, 16'h0000); #1;
        check_eq("lw_mem_ren", 32'(mem_ren[1]), 1);
        check_eq("lw_wb_data", 32'(wb_data_src[1]), 32'(WB_DATA_MEM));
        inst = NOP; #1;

        // EXE then MEM forwarding of r3
        inst = r_type(5'd1, 5'd2, 5'd3, FN_ADD); tick();
        inst = r_type(5'd3, 5'd1, 5'd4, FN_SUB); #1;
        check_eq("fwd_exe_a", 32'(fwd_a_sel[1]), 32'(FWD_EXE));
        check_eq("fwd_exe_b", 32'(fwd_b_sel[1]), 32'(FWD_NONE));
        check_eq("fwd_exe_stall", 32'(stall_if_id[1]), 0);
        check_eq("nofwd_exe_stall", 32'(stall_if_id[0]), 1);
        check_eq("nofwd_exe_fwd", 32'(fwd_a_sel[0]), 0);
        tick();
        inst = r_type(5'd3, 5'd3, 5'd8, FN_AND); #1;
        check_eq("fwd_mem_a", 32'(fwd_a_sel[1]), 32'(FWD_MEM));
        check_eq("fwd_mem_b", 32'(fwd_b_sel[1]), 32'(FWD_MEM));
        tick();
        inst = NOP; tick(); tick();

        // Load-use: 1 stall with forwarding, 2 without
        inst = i_type(OP_LW, 5'd0, 5'd5, 16'h0000); tick();
        inst = r_type(5'd5, 5'd5, 5'd6, FN_ADD); #1;
        check_eq("lu_stall1", 32'(stall_if_id[1]), 1);
        check_eq("lu_nofwd_stall1", 32'(stall_if_id[0]), 1);
        tick();
        check_eq("lu_stall2", 32'(stall_if_id[1]), 0);
        check_eq("lu_fwd_a", 32'(fwd_a_sel[1]), 32'(FWD_MEM));
        check_eq("lu_fwd_b", 32'(fwd_b_sel[1]), 32'(FWD_MEM));
        check_eq("lu_nofwd_stall2", 32'(stall_if_id[0]), 1);
        tick();
        check_eq("lu_nofwd_stall3", 32'(stall_if_id[0]), 0);
        tick();
        inst = NOP; tick(); tick();

        // Taken branch beats a pending load-use stall
        inst = i_type(OP_LW, 5'd0, 5'd5, 16'h0000); tick();
        inst = r_type(5'd5, 5'd5, 5'd6, FN_ADD); #1;
        check_eq("br_pre_stall", 32'(stall_if_id[1]), 1);
        exe_branch_taken = 1'b1; #1;
        check_eq("br_stall", 32'(stall_if_id[1]), 0);
        check_eq("br_nofwd_stall", 32'(stall_if_id[0]), 0);
        check_eq("br_flush_if", 32'(flush_if_id[1]), 1);
        check_eq("br_flush_ex", 32'(flush_id_ex[1]), 1);
        tick();
        exe_branch_taken = 1'b0;

        // r0 destination never creates a hazard
        inst = i_type(OP_LW, 5'd1, 5'd0, 16'h0000); tick();
        inst = r_type(5'd0, 5'd0, 5'd6, FN_ADD); #1;
        check_eq("r0_stall", 32'(stall_if_id[1]), 0);
        check_eq("r0_fwd_a", 32'(fwd_a_sel[1]), 0);
        check_eq("r0_nofwd_stall", 32'(stall_if_id[0]), 0);
        inst = NOP; tick(); tick(); tick();

        // Halt; shadows must not advance while cpu_en is low
        debug_en = 1'b1; tick();
        check_eq("halt_cpu_en", 32'(cpu_en[1]), 0);
        inst = i_type(OP_LW, 5'd0, 5'd5, 16'h0000); tick(); tick();
        inst = r_type(5'd5, 5'd5, 5'd6, FN_ADD); #1;
        check_eq("halt_hold_stall", 32'(stall_if_id[1]), 0);
        inst = NOP;

        debug_step_cnt = 8'd3; debug_step = 1'b1;
        en_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cpu_en[1]) en_cycles++;
        end
        check_eq("step3_cycles", 32'(en_cycles), 3);
        check_eq("step3_halted", 32'(cpu_en[1]), 0);

        debug_step = 1'b0; tick();
        debug_step_cnt = 8'd0; debug_step = 1'b1;
        en_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cpu_en[1]) en_cycles++;
        end
        check_eq("step0_cycles", 32'(en_cycles), 1);

        // debug_en dropped mid-step returns to free-running
        debug_step = 1'b0; tick();
        debug_step_cnt = 8'd5; debug_step = 1'b1; tick(); tick();
        check_eq("mid_step_en", 32'(cpu_en[1]), 1);
        debug_en = 1'b0;
        en_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cpu_en[1]) en_cycles++;
        end
        check_eq("drop_run_cycles", 32'(en_cycles), 8);

        // Reset mid-operation acts immediately
        rst = 1'b0; #1;
        check_eq("abort_cpu_rst", 32'(cpu_rst[1]), 1);
        check_eq("abort_cpu_en", 32'(cpu_en[1]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
